xge_pfc_tx_gate: RTL
====================

XGE_PFC_TX_GATE -- requirements
Module: xge_pfc_tx_gate

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 8, number of priority-flow-control classes (1..8; 1 = legacy 802.3x pause).
REQ-002 SHALL have parameter QUANTA_CYCLES, default 8, xgmii_clk cycles per 512-bit pause quantum.
REQ-003 SHALL have parameter CNT_W, default 16, per-class quanta counter width.
REQ-004 SHALL have port: xgmii_clk  in  1  datapath clock.
REQ-005 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: pause_req  in  1  one-cycle strobe, valid pause/PFC frame received.
REQ-007 SHALL have port: pause_class_en  in  NUM_CLASSES  classes addressed by this frame.
REQ-008 SHALL have port: pause_val  in  NUM_CLASSES*CNT_W  per-class quanta, class i at [i*CNT_W +: CNT_W].
REQ-009 SHALL have ports: s_axis_tdata in 64, s_axis_tuser in 4, s_axis_tlast in 1, s_axis_tvalid in 1, s_axis_tready out 1 (upstream TX stream).
REQ-010 SHALL have port: s_axis_tclass  in  3  packet priority class, stable from first beat to tlast.
REQ-011 SHALL have ports: m_axis_tdata out 64, m_axis_tuser out 4, m_axis_tlast out 1, m_axis_tvalid out 1, m_axis_tready in 1 (toward MAC TX adapter).
REQ-012 SHALL have port: paused  out  NUM_CLASSES  class i counter nonzero.
REQ-013 SHALL have port: pause_events  out  32  saturating count of accepted pause_req strobes.

Function
REQ-014 SHALL run free tick counter 0..QUANTA_CYCLES-1; tick asserted for one cycle at wrap to 0.
REQ-015 SHALL, per class i: on pause_req & pause_class_en[i], load pause_val[i]; else on tick & cnt!=0, decrement by 1.
REQ-016 SHALL give load priority over same-cycle decrement; load of 0 resumes class immediately (next cycle paused[i]=0).
REQ-017 SHALL tolerate pause duration error of up to QUANTA_CYCLES-1 cycles early release (shared tick, not re-phased on load).
REQ-018 SHALL ignore pause_class_en bits >= NUM_CLASSES; class index s_axis_tclass >= NUM_CLASSES maps to class NUM_CLASSES-1.
REQ-019 SHALL implement gate FSM states IDLE, ARMED, IN_PKT.
REQ-020 IDLE: gate open iff ~paused[s_axis_tclass]; beat accepted without tlast -> IN_PKT; single-beat packet (tlast) -> stay IDLE; open & tvalid & ~m_axis_tready -> ARMED.
REQ-021 ARMED: gate held open regardless of pause (AXI valid never withdrawn); accept non-tlast -> IN_PKT, accept tlast -> IDLE.
REQ-022 IN_PKT: gate held open regardless of pause until tlast handshake -> IDLE; pause never truncates a packet.
REQ-023 SHALL pass data with zero latency: m_axis_tvalid = s_axis_tvalid & open, s_axis_tready = m_axis_tready & open, tdata/tuser/tlast direct.
REQ-024 SHALL increment pause_events on each pause_req (any class_en), saturating at 0xFFFFFFFF.

Reset
REQ-025 SHALL on reset: all class counters 0, tick counter 0, FSM IDLE, paused 0, pause_events 0, m_axis_tvalid 0, s_axis_tready follows m_axis_tready.
REQ-026 SHALL on reset mid-packet abandon the packet; upstream restarts from a new first beat.

Structure
REQ-027 SHALL place FSM state enum and pause quantum constant (512 bits) in shared package xge_pkg.
REQ-028 SHALL instantiate one sub-module xge_pause_quanta_cnt per class (load/decrement/paused), generated NUM_CLASSES times.

Verification
REQ-029 Legacy: NUM_CLASSES=1, pause_val=3 at idle -> paused=1 for 17..24 cycles, no m_axis_tvalid while paused, traffic resumes after.
REQ-030 Mid-packet: 10-beat packet, pause_req(class 0, val=100) at beat 4 -> all 10 beats forwarded, next packet held until paused[0]=0.
REQ-031 PFC: class_en=0x04, val=50 -> class 2 packet held, class 5 packet passes with zero latency.
REQ-032 ARMED: first beat offered with m_axis_tready=0, then pause_req -> m_axis_tvalid stays 1 until accepted, packet completes.
REQ-033 Resume/precedence: pause_val=0 to paused class -> paused clears next cycle; pause_req coincident with tick -> loaded value, not decremented.
REQ-034 Reset asserted in IN_PKT with class counters nonzero -> paused=0, pause_events=0, FSM IDLE.

Source files
------------

// File: rtl/xge_pkg.sv
// Shared definitions for the 10GbE TX pause path.
//   PAUSE_QUANTUM_BITS : size of one 802.3x/PFC pause quantum in bit times
//   gate_state_e       : TX gate FSM state encoding
//   map_class()        : folds an out-of-range packet class onto the top class
package xge_pkg;

  localparam int unsigned PAUSE_QUANTUM_BITS = 512;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StInPkt = 2'd2
  } gate_state_e;

  function automatic logic [2:0] map_class(input logic [2:0] tclass,
                                           input int unsigned num_classes);
    if ({29'd0, tclass} >= num_classes) begin
      return 3'(num_classes - 1);
    end
    return tclass;
  endfunction

endpackage

// File: rtl/xge_pause_quanta_cnt.sv
// Per-class pause quanta counter.
//   xgmii_clk : datapath clock
//   reset     : asynchronous, active-high
//   load      : load load_val this cycle (wins over a coincident decrement)
//   load_val  : pause quanta received for this class
//   tick      : one pulse per pause quantum, shared by all classes
//   paused    : counter nonzero
module xge_pause_quanta_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             xgmii_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             paused
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge xgmii_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign paused = (cnt_q != '0);

endmodule

// File: rtl/xge_pfc_tx_gate.sv
// 802.3x / 802.1Qbb pause gate in front of the MAC TX adapter.
// Holds back new packets of paused classes; never truncates a packet in flight.
//   xgmii_clk, reset      : clock, asynchronous active-high reset
//   pause_req             : strobe, valid pause/PFC frame received
//   pause_class_en        : classes addressed by that frame
//   pause_val             : per-class quanta, class i at [i*CNT_W +: CNT_W]
//   s_axis_*              : upstream TX stream (s_axis_tclass = packet priority)
//   m_axis_*              : stream toward the MAC, zero latency
//   paused                : per-class pause active
//   pause_events          : saturating count of pause_req strobes
module xge_pfc_tx_gate
  import xge_pkg::*;
#(
  parameter int unsigned NUM_CLASSES   = 8,
  parameter int unsigned QUANTA_CYCLES = PAUSE_QUANTUM_BITS / 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         xgmii_clk,
  input  logic                         reset,
  input  logic                         pause_req,
  input  logic [NUM_CLASSES-1:0]       pause_class_en,
  input  logic [NUM_CLASSES*CNT_W-1:0] pause_val,
  input  logic [63:0]                  s_axis_tdata,
  input  logic [3:0]                   s_axis_tuser,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [2:0]                   s_axis_tclass,
  output logic [63:0]                  m_axis_tdata,
  output logic [3:0]                   m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [NUM_CLASSES-1:0]       paused,
  output logic [31:0]                  pause_events
);

  localparam int unsigned TICK_W = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;

  // Quantum tick: free running, never re-phased by a load, so a pause may
  // release up to QUANTA_CYCLES-1 cycles early.
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_W'(QUANTA_CYCLES - 1));

  always_ff @(posedge xgmii_clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
    xge_pause_quanta_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .xgmii_clk(xgmii_clk),
      .reset    (reset),
      .load     (pause_req & pause_class_en[i]),
      .load_val (pause_val[i*CNT_W +: CNT_W]),
      .tick     (tick),
      .paused   (paused[i])
    );
  end

  always_ff @(posedge xgmii_clk or posedge reset) begin
    if (reset) begin
      pause_events <= '0;
    end else if (pause_req && (pause_events != 32'hFFFF_FFFF)) begin
      pause_events <= pause_events + 32'd1;
    end
  end

  // Gate: only IDLE looks at the pause state; once a beat has been offered
  // downstream the gate stays open until the packet's tlast handshake.
  gate_state_e state_q;
  logic [2:0]  cls;
  logic [7:0]  paused_ext;
  logic        gate_open;
  logic        beat_acc;

  assign cls        = map_class(s_axis_tclass, NUM_CLASSES);
  assign paused_ext = 8'(paused);
  assign gate_open  = (state_q != StIdle) || !paused_ext[cls];
  assign beat_acc   = s_axis_tvalid && m_axis_tready && gate_open;

  always_ff @(posedge xgmii_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (beat_acc) begin
            state_q <= s_axis_tlast ? StIdle : StInPkt;
          end else if (s_axis_tvalid && gate_open) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (beat_acc) begin
            state_q <= s_axis_tlast ? StIdle : StInPkt;
          end
        end
        StInPkt: begin
          if (beat_acc && s_axis_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Valid is masked during reset; ready keeps following the MAC.
  assign m_axis_tvalid = s_axis_tvalid && gate_open && !reset;
  assign s_axis_tready = m_axis_tready && gate_open;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

endmodule
